dds_fm_lookup_sequencer: RTL and testbench

Per-sample controller for the 1024x16 FM deviation lookup RAM of one DDS channel. On each sample tick it advances a modulation phase accumulator and reads the signed deviation from the RAM's read-only port B (port A stays with the CPU for table loads). It then scales the deviation, adds it to the carrier tuning word, and presents the resulting frequency word to the DDS phase accumulator.

---
 rtl/dds_fm_lookup_sequencer_if.sv | 46 ++++
 rtl/dds_fm_lookup_sequencer.sv | 117 +++++++++++
 tb/tb_dds_fm_lookup_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_fm_lookup_sequencer_if.sv
// Bus bundle between the DDS channel control logic and the FM lookup
// sequencer, including the read-only port B of the deviation RAM.
//
//   sample_tick / fm_enable / carrier_inc / mod_inc / gain_shift
//                 : per-sample request and modulation configuration
//   phase_clr     : synchronous clear of the modulation phase
//   overrun_clr   : clears the sticky overrun flag
//   ram_address / ram_chipselect / ram_readdata
//                 : lookup RAM port B (registered address, unregistered data)
//   freq_word / freq_valid : frequency word to the DDS accumulator
//   busy / overrun         : sequencer status
//
// The slave modport is the sequencer's view; master is the surrounding logic.
interface dds_fm_lookup_sequencer_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = 4
);
  logic               sample_tick;
  logic               fm_enable;
  logic [PHASE_W-1:0] carrier_inc;
  logic [PHASE_W-1:0] mod_inc;
  logic [SHIFT_W-1:0] gain_shift;
  logic               phase_clr;
  logic               overrun_clr;
  logic [ADDR_W-1:0]  ram_address;
  logic               ram_chipselect;
  logic [DATA_W-1:0]  ram_readdata;
  logic [PHASE_W-1:0] freq_word;
  logic               freq_valid;
  logic               busy;
  logic               overrun;

  modport slave (
    input  sample_tick, fm_enable, carrier_inc, mod_inc, gain_shift,
    input  phase_clr, overrun_clr, ram_readdata,
    output ram_address, ram_chipselect, freq_word, freq_valid, busy, overrun
  );

  modport master (
    output sample_tick, fm_enable, carrier_inc, mod_inc, gain_shift,
    output phase_clr, overrun_clr, ram_readdata,
    input  ram_address, ram_chipselect, freq_word, freq_valid, busy, overrun
  );
endinterface

// File: rtl/dds_fm_lookup_sequencer.sv
// Per-sample FM controller for one DDS channel. On each accepted sample tick
// it steps the modulation phase, reads the signed deviation from the lookup
// RAM port B, scales it by a left shift and adds it to the carrier tuning
// word. With FM disabled the carrier word is passed through in one cycle.
//
// Ports:
//   clk     : single clock, shared with RAM port B
//   reset_n : asynchronous active-low reset
//   bus     : dds_fm_lookup_sequencer_if.slave (request, config, RAM port B,
//             frequency word output and status)
module dds_fm_lookup_sequencer #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  dds_fm_lookup_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPT, ST_CALC} state_t;

  state_t                    r_state;
  logic [PHASE_W-1:0]        r_phase;
  logic [PHASE_W-1:0]        r_carrier_snap;
  logic [SHIFT_W-1:0]        r_gain_snap;
  logic signed [DATA_W-1:0]  r_dev;
  logic [ADDR_W-1:0]         r_ram_address;
  logic                      r_ram_cs;
  logic [PHASE_W-1:0]        r_freq_word;
  logic                      r_freq_valid;
  logic                      r_overrun;

  logic [PHASE_W-1:0]        w_phase_base;
  logic                      w_accept;

  // Carrier plus sign-extended, left-shifted deviation; wraps modulo 2^PHASE_W.
  function automatic logic [PHASE_W-1:0] fm_word(
    input logic [PHASE_W-1:0]       carrier,
    input logic signed [DATA_W-1:0] dev,
    input logic [SHIFT_W-1:0]       sh
  );
    logic signed [PHASE_W-1:0] dev_ext;
    dev_ext = {{(PHASE_W-DATA_W){dev[DATA_W-1]}}, dev};
    return carrier + (dev_ext <<< sh);
  endfunction

  // phase_clr takes effect before a coinciding tick, so that tick reads
  // address 0 and leaves the phase at mod_inc.
  assign w_phase_base = bus.phase_clr ? '0 : r_phase;
  assign w_accept     = bus.sample_tick && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_phase        <= '0;
      r_carrier_snap <= '0;
      r_gain_snap    <= '0;
      r_dev          <= '0;
      r_ram_address  <= '0;
      r_ram_cs       <= 1'b0;
      r_freq_word    <= '0;
      r_freq_valid   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      r_ram_cs     <= 1'b0;
      r_phase      <= w_phase_base;

      // Set has priority over clear.
      if (bus.sample_tick && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      else if (bus.overrun_clr)
        r_overrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.fm_enable) begin
              r_ram_address  <= w_phase_base[PHASE_W-1 -: ADDR_W];
              r_phase        <= w_phase_base + bus.mod_inc;
              r_carrier_snap <= bus.carrier_inc;
              r_gain_snap    <= bus.gain_shift;
              // Chip select is registered so it is high exactly in WAIT.
              r_ram_cs       <= 1'b1;
              r_state        <= ST_WAIT;
            end else begin
              r_freq_word  <= bus.carrier_inc;
              r_freq_valid <= 1'b1;
            end
          end
        end
        // RAM latches the address at the end of this cycle.
        ST_WAIT: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_dev   <= $signed(bus.ram_readdata);
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_freq_word  <= fm_word(r_carrier_snap, r_dev, r_gain_snap);
          r_freq_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_address    = r_ram_address;
  assign bus.ram_chipselect = r_ram_cs;
  assign bus.freq_word      = r_freq_word;
  assign bus.freq_valid     = r_freq_valid;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.overrun        = r_overrun;

endmodule

// File: tb/tb_dds_fm_lookup_sequencer.sv
// Bench for dds_fm_lookup_sequencer: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_dds_fm_lookup_sequencer;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dds_fm_lookup_sequencer_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W),
                               .DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus_if ();

  dds_fm_lookup_sequencer #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W),
                            .DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // Lookup RAM port B: registered address, combinational data.
  logic [DATA_W-1:0] mem [0:1023];
  logic [ADDR_W-1:0] ram_q_addr;
  always @(posedge clk) if (bus_if.ram_chipselect) ram_q_addr <= bus_if.ram_address;
  assign bus_if.ram_readdata = mem[ram_q_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: pending results are kept as (due cycle, word) entries.
  typedef struct { int due; logic [31:0] word; } pend_t;
  pend_t       pq[$];
  logic [31:0] m_phase, m_freq_word;
  logic [9:0]  m_addr;
  logic        m_overrun, m_cs, m_valid;
  int          m_busy_left;

  task automatic model_reset();
    m_phase = 0; m_freq_word = 0; m_addr = 0;
    m_overrun = 0; m_cs = 0; m_valid = 0; m_busy_left = 0;
    pq.delete();
  endtask

  task automatic model_edge();
    bit          accept;
    logic [31:0] base;
    int          dv;
    logic [31:0] word;
    accept = bus_if.sample_tick && (m_busy_left == 0);
    if (bus_if.sample_tick && !accept) m_overrun = 1;
    else if (bus_if.overrun_clr) m_overrun = 0;
    base = bus_if.phase_clr ? 32'd0 : m_phase;
    m_cs = 0;
    if (accept && bus_if.fm_enable) begin
      m_addr = base[31:22];
      dv = int'($signed(mem[m_addr]));
      word = bus_if.carrier_inc
           + 32'(longint'(dv) * (longint'(1) << bus_if.gain_shift));
      pq.push_back('{cyc + 4, word});
      m_phase = base + bus_if.mod_inc;
      m_busy_left = 3;
      m_cs = 1;
    end else begin
      m_phase = base;
      if (accept) pq.push_back('{cyc + 1, bus_if.carrier_inc});
      if (m_busy_left > 0) m_busy_left--;
    end
    cyc++;
    m_valid = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      m_valid = 1;
      m_freq_word = pq[0].word;
      void'(pq.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("freq_valid", 32'(bus_if.freq_valid), 32'(m_valid));
    chk("freq_word", bus_if.freq_word, m_freq_word);
    chk("ram_chipselect", 32'(bus_if.ram_chipselect), 32'(m_cs));
    chk("busy", 32'(bus_if.busy), 32'(m_busy_left > 0));
    chk("overrun", 32'(bus_if.overrun), 32'(m_overrun));
    chk("ram_address", 32'(bus_if.ram_address), 32'(m_addr));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic tick1();
    bus_if.sample_tick = 1'b1;
    cycle();
    bus_if.sample_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    reset_n = 1'b0;
    bus_if.sample_tick = 0; bus_if.fm_enable = 1; bus_if.carrier_inc = 0;
    bus_if.mod_inc = 0; bus_if.gain_shift = 0; bus_if.phase_clr = 0;
    bus_if.overrun_clr = 0;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Basic FM
    mem[0] = 16'h0100; mem[1] = 16'h0200;
    bus_if.carrier_inc = 32'h10000000; bus_if.mod_inc = 32'h00400000;
    bus_if.gain_shift = 0;
    tick1();
    chk("basic1_addr", 32'(bus_if.ram_address), 32'd0);
    idle(3);
    chk("basic1_valid", 32'(bus_if.freq_valid), 32'd1);
    chk("basic1_word", bus_if.freq_word, 32'h10000100);
    tick1();
    chk("basic2_addr", 32'(bus_if.ram_address), 32'd1);
    idle(3);
    chk("basic2_word", bus_if.freq_word, 32'h10000200);

    // Negative deviation with gain
    mem[0] = 16'hFF00; bus_if.gain_shift = 4;
    bus_if.phase_clr = 1; cycle(); bus_if.phase_clr = 0;
    tick1(); idle(3);
    chk("neg_word", bus_if.freq_word, 32'h0FFFF000);

    // Phase wrap and phase_clr coinciding with a tick
    bus_if.phase_clr = 1; cycle(); bus_if.phase_clr = 0;
    bus_if.mod_inc = 32'h80000000; bus_if.gain_shift = 0;
    tick1(); chk("wrap_addr0", 32'(bus_if.ram_address), 32'd0); idle(3);
    tick1(); chk("wrap_addr1", 32'(bus_if.ram_address), 32'd512); idle(3);
    bus_if.phase_clr = 1; tick1(); bus_if.phase_clr = 0;
    chk("wrap_clr_addr", 32'(bus_if.ram_address), 32'd0); idle(3);
    tick1(); chk("wrap_after_clr", 32'(bus_if.ram_address), 32'd512); idle(3);

    // Overrun
    tick1(); idle(1); tick1();
    chk("ovr_set", 32'(bus_if.overrun), 32'd1);
    bus_if.overrun_clr = 1; tick1(); bus_if.overrun_clr = 0;
    chk("ovr_set_wins", 32'(bus_if.overrun), 32'd1);
    chk("ovr_single_valid", 32'(bus_if.freq_valid), 32'd1);
    idle(1);
    bus_if.overrun_clr = 1; cycle(); bus_if.overrun_clr = 0;
    chk("ovr_clr", 32'(bus_if.overrun), 32'd0);

    // Bypass
    bus_if.fm_enable = 0; bus_if.carrier_inc = 32'h12345678;
    tick1();
    chk("byp_valid", 32'(bus_if.freq_valid), 32'd1);
    chk("byp_word", bus_if.freq_word, 32'h12345678);
    chk("byp_cs", 32'(bus_if.ram_chipselect), 32'd0);
    idle(2);
    bus_if.fm_enable = 1; bus_if.carrier_inc = 32'h10000000;
    tick1(); idle(3);

    // Asynchronous reset in WAIT
    tick1(); tick1(); idle(2);
    tick1();
    #3 reset_n = 1'b0;
    #1 model_reset();
    chk("rst_cs", 32'(bus_if.ram_chipselect), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_word", bus_if.freq_word, 32'd0);
    chk("rst_overrun", 32'(bus_if.overrun), 32'd0);
    check_all();
    idle(2);
    reset_n = 1'b1;
    idle(6);

    // Random traffic
    repeat (400) begin
      bus_if.sample_tick = (($urandom % 100) < 45);
      bus_if.fm_enable   = (($urandom % 8) != 0);
      bus_if.carrier_inc = $urandom;
      bus_if.mod_inc     = $urandom;
      bus_if.gain_shift  = 4'($urandom);
      bus_if.phase_clr   = (($urandom % 16) == 0);
      bus_if.overrun_clr = (($urandom % 6) == 0);
      if (m_busy_left == 0 && ($urandom % 4) == 0)
        mem[10'($urandom)] = 16'($urandom);
      cycle();
    end
    bus_if.sample_tick = 0; bus_if.phase_clr = 0; bus_if.overrun_clr = 0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
